// File: rtl/osc_clk_enable_gen.sv
// Multi-channel clock-enable generator: startup hold-off, then per-channel CE strobes with
// glitch-free ratio updates on period boundaries. Define OSC_DIV_CLK_EN to add DIV_CLK outputs.
module osc_clk_enable_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int STARTUP_CYC = 1024,
    parameter int DEFAULT_DIV = 160,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [NUM_CH-1:0] CH_EN,
    input  logic              DIV_WR,
    input  logic [CH_W-1:0]   DIV_SEL,
    input  logic [DIV_W-1:0]  DIV_DATA,
    output logic              DIV_ACK,
    output logic              READY,
    output logic [NUM_CH-1:0] CE
`ifdef OSC_DIV_CLK_EN
    ,
    output logic [NUM_CH-1:0] DIV_CLK
`endif
);

    localparam int ST_W = $clog2(STARTUP_CYC + 1);

    logic [ST_W-1:0]   st_cnt_q, st_cnt_d;
    logic              ready_q, ready_d;
    logic              ack_q, ack_d;
    logic [NUM_CH-1:0] ce_q, ce_d;
    logic [DIV_W-1:0]  cnt_q   [NUM_CH];
    logic [DIV_W-1:0]  cnt_d   [NUM_CH];
    logic [DIV_W-1:0]  ratio_q [NUM_CH];
    logic [DIV_W-1:0]  ratio_d [NUM_CH];
    logic [DIV_W-1:0]  pend_q  [NUM_CH];
    logic [DIV_W-1:0]  pend_d  [NUM_CH];
    logic [NUM_CH-1:0] pend_v_q, pend_v_d;
    logic [NUM_CH-1:0] active_s, term_s;
    logic [DIV_W-1:0]  wr_data_s;

    // Startup window counter; freezes once READY is set.
    always_comb begin
        st_cnt_d = st_cnt_q;
        ready_d  = ready_q;
        if (!ready_q) begin
            st_cnt_d = st_cnt_q + ST_W'(1);
            if (st_cnt_q == ST_W'(STARTUP_CYC - 1)) begin
                ready_d = 1'b1;
            end else begin
                ready_d = 1'b0;
            end
        end else begin
            st_cnt_d = st_cnt_q;
        end
    end

    // Per-channel activity and terminal-edge detection.
    always_comb begin
        active_s = '0;
        term_s   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            active_s[i] = ready_q & CH_EN[i];
            term_s[i]   = active_s[i] & (cnt_q[i] == (ratio_q[i] - DIV_W'(1)));
        end
    end

    // Counters, CE strobes, ratio apply and pending-ratio writes.
    always_comb begin
        ack_d     = DIV_WR;
        wr_data_s = (DIV_DATA == '0) ? DIV_W'(1) : DIV_DATA;
        ce_d      = '0;
        pend_v_d  = pend_v_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]   = cnt_q[i];
            ratio_d[i] = ratio_q[i];
            pend_d[i]  = pend_q[i];
            if (!active_s[i]) begin
                cnt_d[i] = '0;
                ce_d[i]  = 1'b0;
            end else if (term_s[i]) begin
                cnt_d[i] = '0;
                ce_d[i]  = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + DIV_W'(1);
                ce_d[i]  = 1'b0;
            end
            // No period is in flight when idle, so a pending ratio can land at once.
            if ((!active_s[i] || term_s[i]) && pend_v_q[i]) begin
                ratio_d[i]  = pend_q[i];
                pend_v_d[i] = 1'b0;
            end else begin
                ratio_d[i]  = ratio_q[i];
            end
            // A same-edge write lands after the apply, so it becomes the next pending value.
            if (DIV_WR && (DIV_SEL == CH_W'(i))) begin
                pend_d[i]   = wr_data_s;
                pend_v_d[i] = 1'b1;
            end else begin
                pend_d[i]   = pend_q[i];
            end
        end
    end

    // State registers.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            st_cnt_q <= '0;
            ready_q  <= 1'b0;
            ack_q    <= 1'b0;
            ce_q     <= '0;
            pend_v_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]   <= '0;
                ratio_q[i] <= DIV_W'(DEFAULT_DIV);
                pend_q[i]  <= DIV_W'(DEFAULT_DIV);
            end
        end else begin
            st_cnt_q <= st_cnt_d;
            ready_q  <= ready_d;
            ack_q    <= ack_d;
            ce_q     <= ce_d;
            pend_v_q <= pend_v_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]   <= cnt_d[i];
                ratio_q[i] <= ratio_d[i];
                pend_q[i]  <= pend_d[i];
            end
        end
    end

    assign READY   = ready_q;
    assign DIV_ACK = ack_q;
    assign CE      = ce_q;

`ifdef OSC_DIV_CLK_EN
    logic [NUM_CH-1:0] div_clk_q, div_clk_d;

    // Square clock toggles on each CE-raising edge, held low when idle.
    always_comb begin
        div_clk_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!active_s[i]) begin
                div_clk_d[i] = 1'b0;
            end else if (term_s[i]) begin
                div_clk_d[i] = ~div_clk_q[i];
            end else begin
                div_clk_d[i] = div_clk_q[i];
            end
        end
    end

    // Divided clock register; must pass through CLKINT before clock use.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            div_clk_q <= '0;
        end else begin
            div_clk_q <= div_clk_d;
        end
    end

    assign DIV_CLK = div_clk_q;
`endif

endmodule

// File: tb/tb_osc_clk_enable_gen.sv
// Self-checking bench for osc_clk_enable_gen: per-edge scoreboard from a countdown
// reference model plus directed startup/pulse-position checks.
module tb_osc_clk_enable_gen;

    localparam int NUM_CH  = 4;
    localparam int STARTUP = 1024;
    localparam int DEF_DIV = 160;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ch_en = 4'b0000;
    logic        div_wr = 1'b0;
    logic [1:0]  div_sel = 2'd0;
    logic [15:0] div_data = 16'd0;
    logic        div_ack;
    logic        ready;
    logic [3:0]  ce;
    logic [3:0]  div_clk_s;

    always #5 clk = ~clk;

`ifdef OSC_DIV_CLK_EN
    logic [3:0] div_clk;
    assign div_clk_s = div_clk;
`else
    assign div_clk_s = 4'b0000;
`endif

    osc_clk_enable_gen #(
        .NUM_CH(NUM_CH), .DIV_W(16), .STARTUP_CYC(STARTUP), .DEFAULT_DIV(DEF_DIV)
    ) dut (
        .CLK(clk), .RESETN(rst_n), .CH_EN(ch_en), .DIV_WR(div_wr),
        .DIV_SEL(div_sel), .DIV_DATA(div_data), .DIV_ACK(div_ack),
        .READY(ready), .CE(ce)
`ifdef OSC_DIV_CLK_EN
        , .DIV_CLK(div_clk)
`endif
    );

    logic [9:0] sb_q[$];
    int checks = 0;
    int fails  = 0;

    bit m_ready;
    bit m_ack;
    int m_scnt;
    int m_rem   [4];
    int m_ratio [4];
    int m_pend  [4];
    bit m_pv    [4];
    bit m_ce    [4];
    bit m_dclk  [4];

    function automatic void model_reset();
        m_ready = 1'b0;
        m_ack   = 1'b0;
        m_scnt  = 0;
        for (int i = 0; i < 4; i++) begin
            m_rem[i] = 0; m_ratio[i] = DEF_DIV; m_pend[i] = DEF_DIV;
            m_pv[i] = 1'b0; m_ce[i] = 1'b0; m_dclk[i] = 1'b0;
        end
    endfunction

    // Countdown model: remaining edges until the next pulse; 0 means "start a fresh period".
    function automatic void model_edge();
        bit act;
        m_ack = div_wr;
        for (int i = 0; i < 4; i++) begin
            act = m_ready && ch_en[i];
            if (!act) begin
                m_rem[i] = 0; m_ce[i] = 1'b0; m_dclk[i] = 1'b0;
                if (m_pv[i]) begin m_ratio[i] = m_pend[i]; m_pv[i] = 1'b0; end
            end else begin
                if (m_rem[i] == 0) m_rem[i] = m_ratio[i];
                m_rem[i] = m_rem[i] - 1;
                if (m_rem[i] == 0) begin
                    m_ce[i] = 1'b1; m_dclk[i] = ~m_dclk[i];
                    if (m_pv[i]) begin m_ratio[i] = m_pend[i]; m_pv[i] = 1'b0; end
                end else begin
                    m_ce[i] = 1'b0;
                end
            end
        end
        if (div_wr && (int'(div_sel) < NUM_CH)) begin
            m_pend[div_sel] = (div_data == 16'd0) ? 1 : int'(div_data);
            m_pv[div_sel]   = 1'b1;
        end
        if (!m_ready) begin
            m_scnt = m_scnt + 1;
            if (m_scnt == STARTUP) m_ready = 1'b1;
        end
    endfunction

    function automatic logic [9:0] pack_exp();
        logic [9:0] v;
        v = {m_ready, m_ack, 8'b0};
        for (int i = 0; i < 4; i++) begin
            v[4 + i] = m_ce[i];
`ifdef OSC_DIV_CLK_EN
            v[i] = m_dclk[i];
`endif
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input int n, input string tag);
        logic [9:0] e;
        for (int c = 0; c < n; c++) begin
            model_edge();
            sb_q.push_back(pack_exp());
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            check(tag, {ready, div_ack, ce, div_clk_s}, e);
        end
    endtask

    task automatic wr(input logic [1:0] s, input logic [15:0] d, input string tag);
        div_wr = 1'b1; div_sel = s; div_data = d;
        step(1, tag);
        div_wr = 1'b0;
    endtask

    initial begin
        model_reset();
        // 1: reset state, startup window and first CE[0] pulses
        ch_en = 4'b0001;
        #2;
        check("reset_state", {ready, div_ack, ce, div_clk_s}, 10'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(STARTUP - 1, "startup");
        check("ready_before_1024", {9'd0, ready}, 10'd0);
        step(1, "startup_last");
        check("ready_at_1024", {9'd0, ready}, 10'd1);
        for (int p = 0; p < 3; p++) begin
            step(DEF_DIV - 1, "ch0_period");
            check("ce0_not_early", {6'd0, ce}, 10'd0);
            step(1, "ch0_pulse");
            check("ce0_pulse", {6'd0, ce}, 10'b0000000001);
        end

        // 2: mid-period write to ch1
        ch_en = 4'b0011;
        step(50, "ch1_run");
        wr(2'd1, 16'd10, "ch1_write");
        check("ack_pulse", {9'd0, div_ack}, 10'd1);
        step(1, "ch1_after_ack");
        check("ack_single", {9'd0, div_ack}, 10'd0);
        step(400, "ch1_ratio10");

        // 3: ratio 0 then 1 on ch2 -> CE held high after boundary
        ch_en = 4'b0111;
        step(20, "ch2_run");
        wr(2'd2, 16'd0, "ch2_write0");
        wr(2'd2, 16'd1, "ch2_write1");
        step(300, "ch2_ratio1");
        check("ce2_held", {9'd0, ce[2]}, 10'd1);

        // 4: last write wins on ch0
        wr(2'd0, 16'd7, "ch0_write7");
        wr(2'd0, 16'd12, "ch0_write12");
        step(400, "ch0_ratio12");

        // 5: async reset mid-operation, writes accepted before READY
        step(37, "pre_reset");
        rst_n = 1'b0;
        #2;
        check("reset_mid_op", {ready, div_ack, ce, div_clk_s}, 10'd0);
        model_reset();
        ch_en = 4'b0001;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        step(100, "restart");
        wr(2'd3, 16'd4, "ch3_write_early");
        step(STARTUP - 102, "restart_startup");
        check("ready_again_lo", {9'd0, ready}, 10'd0);
        step(1, "restart_last");
        check("ready_again_hi", {9'd0, ready}, 10'd1);
        step(DEF_DIV - 1, "ch0_default");
        check("ratio_reset_lo", {6'd0, ce}, 10'd0);
        step(1, "ch0_default_pulse");
        check("ratio_reset_hi", {6'd0, ce}, 10'b0000000001);

        // 6: ch3 ratio 4, then disable
        ch_en = 4'b1001;
        step(40, "ch3_ratio4");
        ch_en = 4'b0001;
        step(5, "ch3_off");
        check("ce3_off", {9'd0, ce[3]}, 10'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
